// File: rtl/adder_driver.sv
// Drives an external compute unit: latches an operand pair, pulses start, waits for done, then holds the result until it is taken.
// Optional WAIT-state timeout is enabled by defining ADDER_DRIVER_TIMEOUT_EN.
module adder_driver #(
    parameter int N       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         start,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out,
    input  logic         done,
    input  logic [N:0]   result_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_data,
    output logic         busy,
    output logic         err_timeout,
    output logic [15:0]  ops_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0] state;
    logic       wait_expire;

    assign in_ready = (state == IDLE);
    assign start    = (state == ISSUE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            a_out     <= '0;
            b_out     <= '0;
            ops_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_out <= in_a;
                        b_out <= in_b;
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    // done wins over an expiring timeout in the same cycle
                    if (done) begin
                        out_data  <= result_in;
                        out_valid <= 1'b1;
                        ops_count <= ops_count + 16'd1;
                        state     <= HOLD;
                    end else if (wait_expire) begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDER_DRIVER_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    // Expires on the TIMEOUT-th consecutive WAIT cycle without done.
    assign wait_expire = (state == WAIT) && !done && (wait_cnt == 8'(TIMEOUT - 1));
    assign err_timeout = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ISSUE)
                wait_cnt <= '0;
            else if ((state == WAIT) && !done)
                wait_cnt <= wait_cnt + 8'd1;
            if (wait_expire)
                err_q <= 1'b1;
        end
    end
`else
    assign wait_expire = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
